fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a show-ahead FIFO, sending back-to-back frames with no idle gap.
// tx and done are registered; fifo_rd_en is combinational so a pop can chain off the last stop cycle.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntLast);

    // Gated by rst_n so no pop can be requested while held in reset.
    assign fifo_rd_en = rst_n & enable & ~fifo_empty &
                        ((state_q == StIdle) | ((state_q == StStop) & bit_end));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                    tx_d      = shreg_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[bit_idx_q + 3'd1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // A pop overrides the stop-to-idle transition, giving zero-gap back-to-back frames.
        if (fifo_rd_en) begin
            state_d   = StStart;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            shreg_d   = fifo_data;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based line model predicts tx/busy/done/fifo_rd_en every cycle,
// and directed scenarios pin frame contents and timing with hand-computed literals.
module tb_fifo_uart_tx;

    localparam int unsigned Cpb = 4;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       done;

    fifo_uart_tx #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic txb;
        logic last;
    } cyc_t;

    int         checks = 0;
    int         failures = 0;
    cyc_t       line_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] popped[$];
    logic       tx_log[$];
    int         pop_cyc[$];
    int         done_cyc[$];
    logic       done_pend;
    logic       pop_now;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    // Expected line: start 0, data LSB first, stop 1, each held Cpb cycles.
    task automatic push_frame(input logic [7:0] b);
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < int'(Cpb); c++) begin
                cyc_t e;
                if (bi == 0) e.txb = 1'b0;
                else if (bi == 9) e.txb = 1'b1;
                else e.txb = b[bi-1];
                e.last = (bi == 9) && (c == int'(Cpb) - 1);
                line_q.push_back(e);
            end
        end
    endtask

    task automatic compare_cycle();
        logic exp_busy, exp_tx, front_last, exp_rd;
        int   idx;
        exp_busy   = (line_q.size() > 0);
        exp_tx     = exp_busy ? line_q[0].txb : 1'b1;
        front_last = exp_busy && line_q[0].last;
        exp_rd     = rst_n && enable && !fifo_empty && (!exp_busy || front_last);
        check("tx", {31'd0, tx}, {31'd0, exp_tx});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("done", {31'd0, done}, {31'd0, done_pend});
        check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        idx = tx_log.size();
        tx_log.push_back(tx);
        if (fifo_rd_en) pop_cyc.push_back(idx);
        if (done) done_cyc.push_back(idx);
        done_pend = front_last;
        if (exp_busy) void'(line_q.pop_front());
        if (exp_rd) push_frame(fifo_data);
        pop_now = fifo_rd_en;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            popped.push_back(fifo_q.pop_front());
            refresh_fifo();
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        pop_cyc.delete();
        done_cyc.delete();
        popped.delete();
    endtask

    task automatic wait_pops(input int count, input int bound);
        int n = 0;
        while (pop_cyc.size() < count && n < bound) begin
            tick();
            n++;
        end
        check("pop_timeout", pop_cyc.size(), count);
    endtask

    // pat[i] is the required tx during bit period i of a frame popped at sample p.
    task automatic check_frame(input string name, input int p, input logic [9:0] pat);
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < int'(Cpb); c++) begin
                int i = p + 1 + int'(Cpb) * bi + c;
                if (i < tx_log.size()) check(name, {31'd0, tx_log[i]}, {31'd0, pat[bi]});
                else check({name, "_short"}, i, tx_log.size());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int p;
        rst_n     = 1'b1;
        enable    = 1'b0;
        done_pend = 1'b0;
        pop_now   = 1'b0;
        refresh_fifo();
        #1 rst_n = 1'b0;

        // Reset: outputs idle and no pop even with a byte waiting and enable high.
        repeat (2) tick();
        enable = 1'b1;
        fifo_q.push_back(8'hEE);
        refresh_fifo();
        #1;
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        repeat (2) tick();
        fifo_q.delete();
        refresh_fifo();
        enable = 1'b0;
        rst_n  = 1'b1;

        // Empty FIFO, enabled.
        clear_logs();
        enable = 1'b1;
        repeat (100) tick();
        lows = 0;
        foreach (tx_log[i]) if (tx_log[i] == 1'b0) lows++;
        check("empty_pops", pop_cyc.size(), 0);
        check("empty_tx_low", lows, 0);

        // Non-empty FIFO, disabled.
        clear_logs();
        enable = 1'b0;
        fifo_q.push_back(8'h11);
        refresh_fifo();
        repeat (100) tick();
        lows = 0;
        foreach (tx_log[i]) if (tx_log[i] == 1'b0) lows++;
        check("dis_pops", pop_cyc.size(), 0);
        check("dis_tx_low", lows, 0);
        fifo_q.delete();
        refresh_fifo();

        // Single byte 0xA5.
        clear_logs();
        fifo_q.push_back(8'hA5);
        refresh_fifo();
        enable = 1'b1;
        wait_pops(1, 10);
        repeat (50) tick();
        check("a5_pops", pop_cyc.size(), 1);
        check("a5_dones", done_cyc.size(), 1);
        if (popped.size() == 1) check("a5_byte", {24'd0, popped[0]}, 32'hA5);
        if (pop_cyc.size() == 1) begin
            p = pop_cyc[0];
            check_frame("a5_bit", p, 10'b1101001010);
            if (done_cyc.size() == 1) check("a5_done_at", done_cyc[0] - p, 41);
        end
        check("a5_idle_tx", {31'd0, tx}, 32'd1);
        check("a5_idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back 0x00 then 0xFF.
        clear_logs();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        refresh_fifo();
        wait_pops(1, 10);
        repeat (100) tick();
        check("b2b_pops", pop_cyc.size(), 2);
        check("b2b_dones", done_cyc.size(), 2);
        if (pop_cyc.size() == 2 && done_cyc.size() == 2) begin
            p = pop_cyc[0];
            check("b2b_gap", pop_cyc[1] - p, 40);
            check_frame("b2b_f0", p, 10'b1000000000);
            check_frame("b2b_f1", p + 40, 10'b1111111110);
            check("b2b_done0", done_cyc[0] - p, 41);
            check("b2b_done1", done_cyc[1] - p, 81);
        end

        // Enable dropped during 0x3C data bits.
        clear_logs();
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h81);
        refresh_fifo();
        wait_pops(1, 10);
        repeat (10) tick();
        enable = 1'b0;
        repeat (80) tick();
        check("drop_pops", pop_cyc.size(), 1);
        check("drop_dones", done_cyc.size(), 1);
        check("drop_left", fifo_q.size(), 1);
        if (pop_cyc.size() >= 1) check_frame("drop_3c", pop_cyc[0], 10'b1001111000);
        enable = 1'b1;
        wait_pops(2, 10);
        repeat (45) tick();
        check("drop_dones2", done_cyc.size(), 2);
        if (popped.size() == 2) check("drop_byte2", {24'd0, popped[1]}, 32'h81);
        if (pop_cyc.size() == 2) check_frame("drop_81", pop_cyc[1], 10'b1100000010);

        // Reset during data bit 3 of 0x5A.
        clear_logs();
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h77);
        refresh_fifo();
        wait_pops(1, 10);
        repeat (18) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        line_q.delete();
        done_pend = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        wait_pops(2, 10);
        repeat (45) tick();
        check("mid_pops", popped.size(), 2);
        check("mid_dones", done_cyc.size(), 1);
        if (popped.size() == 2) begin
            check("mid_byte0", {24'd0, popped[0]}, 32'h5A);
            check("mid_byte1", {24'd0, popped[1]}, 32'h77);
        end
        if (pop_cyc.size() == 2) check_frame("mid_77", pop_cyc[1], 10'b1011101110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
